// File: rtl/memory_responder.sv
// Fixed-latency, fully pipelined word RAM answering memory_io requests.
// Byte-lane write and read masks, read-before-write, one response per request.
module memory_responder #(
    parameter int    DEPTH_WORDS = 16384,
    parameter int    LATENCY     = 1,
    parameter string INIT_FILE   = "",
    parameter int    ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [3:0]        req_do_read,
    input  logic [3:0]        req_do_write,
    output logic              rsp_valid,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [31:0]       rsp_data
);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    genvar gi;

    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
        $fatal(1, "memory_responder: LATENCY %0d outside 1..8", LATENCY);
    end
    if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $fatal(1, "memory_responder: DEPTH_WORDS %0d is not a power of 2", DEPTH_WORDS);
    end
    if (ADDR_W < IDX_W + 2) begin : g_bad_addr
        $fatal(1, "memory_responder: ADDR_W %0d too narrow for DEPTH_WORDS", ADDR_W);
    end

    logic [31:0] mem [DEPTH_WORDS];

    logic             accept;
    logic [IDX_W-1:0] req_idx;
    logic [31:0]      rd_word_q;

    // A request on the reset edge is dropped entirely, including its write.
    assign accept  = req_valid & ~reset;
    assign req_idx = req_addr[IDX_W+1:2];

    // Read-first RAM: the captured word is the value before this edge's write.
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_word_q <= mem[req_idx];
            for (int i = 0; i < 4; i++) begin
                if (req_do_write[i]) begin
                    mem[req_idx][8*i +: 8] <= req_data[8*i +: 8];
                end
            end
        end
    end

    logic [LATENCY-1:0]             stg_valid;
    logic [LATENCY-1:0][ADDR_W-1:0] stg_addr;
    logic [LATENCY-1:0][3:0]        stg_lanes;
    logic [LATENCY-1:0][31:0]       stg_word;

    for (gi = 0; gi < LATENCY; gi++) begin : g_stage
        logic              in_valid;
        logic [ADDR_W-1:0] in_addr;
        logic [3:0]        in_lanes;
        logic              valid_q, valid_d;
        logic [ADDR_W-1:0] addr_q, addr_d;
        logic [3:0]        lanes_q, lanes_d;

        if (gi == 0) begin : g_head
            assign in_valid      = accept;
            assign in_addr       = req_addr;
            assign in_lanes      = req_do_read;
            assign stg_word[gi]  = rd_word_q;
        end else begin : g_tail
            logic [31:0] word_q, word_d;

            assign in_valid = stg_valid[gi-1];
            assign in_addr  = stg_addr[gi-1];
            assign in_lanes = stg_lanes[gi-1];

            always_comb begin
                word_d = word_q;
                if (stg_valid[gi-1]) begin
                    word_d = stg_word[gi-1];
                end
            end

            always_ff @(posedge clk) begin
                word_q <= word_d;
            end

            assign stg_word[gi] = word_q;
        end

        // Payload only moves with a valid entry, so idle outputs hold their last value.
        always_comb begin
            valid_d = in_valid & ~reset;
            addr_d  = addr_q;
            lanes_d = lanes_q;
            if (reset) begin
                addr_d  = '0;
                lanes_d = '0;
            end else if (in_valid) begin
                addr_d  = in_addr;
                lanes_d = in_lanes;
            end
        end

        always_ff @(posedge clk) begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            lanes_q <= lanes_d;
        end

        assign stg_valid[gi] = valid_q;
        assign stg_addr[gi]  = addr_q;
        assign stg_lanes[gi] = lanes_q;
    end

    assign rsp_valid = stg_valid[LATENCY-1];
    assign rsp_addr  = stg_addr[LATENCY-1];

    // Unread lanes return zero; the cleared lane mask also zeroes data after reset.
    for (gi = 0; gi < 4; gi++) begin : g_lane
        assign rsp_data[8*gi +: 8] = stg_word[LATENCY-1][8*gi +: 8] & {8{stg_lanes[LATENCY-1][gi]}};
    end

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: LATENCY=1 and LATENCY=3 instances share one request
// stream; responses are checked against a byte-array reference model and directed vectors.
module tb_memory_responder;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 32;

    logic              clk;
    logic              reset;
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_data;
    logic [3:0]        req_do_read;
    logic [3:0]        req_do_write;
    logic              rsp1_valid, rsp3_valid;
    logic [ADDR_W-1:0] rsp1_addr, rsp3_addr;
    logic [31:0]       rsp1_data, rsp3_data;

    memory_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .INIT_FILE(""), .ADDR_W(ADDR_W)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_do_read(req_do_read), .req_do_write(req_do_write),
        .rsp_valid(rsp1_valid), .rsp_addr(rsp1_addr), .rsp_data(rsp1_data)
    );

    memory_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(3), .INIT_FILE(""), .ADDR_W(ADDR_W)) dut3 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_do_read(req_do_read), .req_do_write(req_do_write),
        .rsp_valid(rsp3_valid), .rsp_addr(rsp3_addr), .rsp_data(rsp3_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          due;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  rd;
        logic [3:0]  wr;
        logic [31:0] exp;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    int   edge_n = 0;
    bit   mon_en = 0;
    exp_t q1[$];
    exp_t q3[$];
    logic [7:0] mem_m [4*DEPTH];

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic cmp_rsp(input string nm, input bit has, input exp_t e,
                           input logic v, input logic [31:0] a, input logic [31:0] d);
        checks++;
        if (v !== has) begin
            errors++;
            $display("FAIL %s valid at edge %0d: got %b, required %0b", nm, edge_n, v, has);
        end else if (has) begin
            checks++;
            if (a !== e.addr || d !== e.data) begin
                errors++;
                $display("FAIL %s rsp: got addr=%h data=%h, required addr=%h data=%h",
                         nm, a, d, e.addr, e.data);
            end else begin
                $display("%s rsp addr=%h data=%h", nm, a, d);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e1, e3;
            bit   h1, h3;
            e1 = '{0, '0, '0};
            e3 = '{0, '0, '0};
            h1 = (q1.size() > 0) && (q1[0].due == edge_n);
            h3 = (q3.size() > 0) && (q3[0].due == edge_n);
            if (h1) e1 = q1.pop_front();
            if (h3) e3 = q3.pop_front();
            cmp_rsp("L1", h1, e1, rsp1_valid, rsp1_addr, rsp1_data);
            cmp_rsp("L3", h3, e3, rsp3_valid, rsp3_addr, rsp3_data);
        end
    end

    // Present one request for one cycle; the model predicts its response unless a
    // directed expectation is supplied.
    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] rd, input logic [3:0] wr,
                         input bit use_tab, input logic [31:0] tab_exp);
        logic [31:0] pred;
        int          base;
        req_valid    = v;
        req_addr     = a;
        req_data     = d;
        req_do_read  = rd;
        req_do_write = wr;
        if (v && !reset) begin
            base = int'(a % (4 * DEPTH));
            base = base - (base % 4);
            pred = '0;
            for (int i = 0; i < 4; i++) begin
                if (rd[i]) pred[8*i +: 8] = mem_m[base + i];
                if (wr[i]) mem_m[base + i] = d[8*i +: 8];
            end
            if (use_tab) pred = tab_exp;
            q1.push_back('{edge_n + 1, a, pred});
            q3.push_back('{edge_n + 3, a, pred});
        end
        @(posedge clk);
        #1;
    endtask

    // Reset for n edges with a write request present; in-flight responses not yet shown are lost.
    task automatic rst(input int n, input logic [31:0] a);
        reset = 1'b1;
        for (int i = q1.size() - 1; i >= 0; i--) if (q1[i].due > edge_n) q1.delete(i);
        for (int i = q3.size() - 1; i >= 0; i--) if (q3[i].due > edge_n) q3.delete(i);
        for (int i = 0; i < n; i++) drive(1'b1, a, 32'hFFFF_FFFF, 4'hF, 4'hF, 1'b0, '0);
        reset = 1'b0;
    endtask

    vec_t vecs [18];

    initial begin
        vecs[0]  = '{32'h0000_0100, 32'hDEAD_BEEF, 4'h0, 4'hF, 32'h0000_0000};
        vecs[1]  = '{32'h0000_0100, 32'h0000_0000, 4'hF, 4'h0, 32'hDEAD_BEEF};
        vecs[2]  = '{32'h0000_0200, 32'h1122_3344, 4'h0, 4'hF, 32'h0000_0000};
        vecs[3]  = '{32'h0000_0200, 32'h0000_AA00, 4'h0, 4'h2, 32'h0000_0000};
        vecs[4]  = '{32'h0000_0200, 32'h0000_0000, 4'hF, 4'h0, 32'h1122_AA44};
        vecs[5]  = '{32'h0000_0200, 32'h0000_0000, 4'h2, 4'h0, 32'h0000_AA00};
        vecs[6]  = '{32'h0000_0040, 32'h0000_0005, 4'h0, 4'hF, 32'h0000_0000};
        vecs[7]  = '{32'h0000_0040, 32'h0000_0009, 4'hF, 4'hF, 32'h0000_0005};
        vecs[8]  = '{32'h0000_0040, 32'h0000_0000, 4'hF, 4'h0, 32'h0000_0009};
        vecs[9]  = '{32'h0000_0044, 32'hFFFF_FFFF, 4'h0, 4'h0, 32'h0000_0000};
        vecs[10] = '{32'h0000_0103, 32'h0000_0000, 4'hF, 4'h0, 32'hDEAD_BEEF};
        vecs[11] = '{32'h0000_0500, 32'h0000_0000, 4'hF, 4'h0, 32'hDEAD_BEEF};
        vecs[12] = '{32'hFFFF_F100, 32'h0000_0000, 4'h3, 4'h0, 32'h0000_BEEF};
        vecs[13] = '{32'h0000_0408, 32'hCAFE_F00D, 4'h0, 4'hF, 32'h0000_0000};
        vecs[14] = '{32'h0000_0008, 32'h0000_0000, 4'hF, 4'h0, 32'hCAFE_F00D};
        vecs[15] = '{32'h0000_0200, 32'h0000_0000, 4'h9, 4'h0, 32'h1100_0044};
        vecs[16] = '{32'h0000_0300, 32'hA5A5_A5A5, 4'h0, 4'hF, 32'h0000_0000};
        vecs[17] = '{32'h0000_0300, 32'h1234_0000, 4'hC, 4'hC, 32'hA5A5_0000};

        // Power-up reset held two edges with a write request present.
        reset        = 1'b1;
        req_valid    = 1'b1;
        req_addr     = 32'h0000_0300;
        req_data     = 32'h5A5A_5A5A;
        req_do_read  = 4'hF;
        req_do_write = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        chk("reset rsp_addr L1", rsp1_addr, 32'h0);
        chk("reset rsp_data L1", rsp1_data, 32'h0);
        chk("reset rsp_addr L3", rsp3_addr, 32'h0);
        chk("reset rsp_data L3", rsp3_data, 32'h0);

        // Directed vectors, back to back.
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, vecs[i].addr, vecs[i].data, vecs[i].rd, vecs[i].wr, 1'b1, vecs[i].exp);
        end

        // A write on the reset edge must not land in memory.
        rst(2, 32'h0000_0300);
        drive(1'b1, 32'h0000_0300, 32'h0, 4'hF, 4'h0, 1'b1, 32'h1234_A5A5);
        repeat (3) drive(1'b0, '0, '0, 4'h0, 4'h0, 1'b0, '0);

        // Fill words 0..31, then eight back-to-back reads.
        for (int w = 0; w < 32; w++) drive(1'b1, 32'(w * 4), $urandom(), 4'h0, 4'hF, 1'b0, '0);
        for (int k = 0; k < 8; k++) drive(1'b1, 32'(k * 4), '0, 4'hF, 4'h0, 1'b0, '0);
        repeat (4) drive(1'b0, '0, '0, 4'h0, 4'h0, 1'b0, '0);

        // Random traffic over words 0..31 with aliasing upper address bits.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            if (n == 150) rst(1, 32'h0000_0010);
            if ($urandom_range(3) == 0) begin
                drive(1'b0, $urandom(), $urandom(), 4'(($urandom_range(15))), 4'h0, 1'b0, '0);
            end else begin
                a = ($urandom() & 32'hFFFF_FC00) | 32'($urandom_range(31) * 4) | 32'($urandom_range(3));
                drive(1'b1, a, $urandom(), 4'($urandom_range(15)), 4'($urandom_range(15)), 1'b0, '0);
            end
        end

        // Reset with two reads in flight, then an aliased read of word 0.
        drive(1'b1, 32'h0000_0000, 32'h0BAD_CAFE, 4'h0, 4'hF, 1'b0, '0);
        drive(1'b1, 32'h0000_0000, '0, 4'hF, 4'h0, 1'b0, '0);
        drive(1'b1, 32'h0000_0004, '0, 4'hF, 4'h0, 1'b0, '0);
        rst(1, 32'h0000_0000);
        repeat (4) drive(1'b0, '0, '0, 4'h0, 4'h0, 1'b0, '0);
        drive(1'b1, 32'(4 * DEPTH), '0, 4'hF, 4'h0, 1'b1, 32'h0BAD_CAFE);

        repeat (6) drive(1'b0, '0, '0, 4'h0, 4'h0, 1'b0, '0);
        @(negedge clk);
        #1;
        chk("pending responses", 32'(q1.size() + q3.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
